// File: rtl/nf10_sched_pkg.sv
// Shared definitions for the NetFPGA-10G packet schedulers.
// Holds the FSM state type, a constant clog2 and the packed-weight slice helper.
package nf10_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_t;

  localparam int MAX_QUEUES       = 16;
  localparam int MAX_WEIGHT_WIDTH = 8;
  localparam int WBUS_MAX         = MAX_QUEUES * MAX_WEIGHT_WIDTH;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Callers zero-extend their weights bus to WBUS_MAX and truncate the result.
  function automatic logic [MAX_WEIGHT_WIDTH-1:0] weight_at(
    input logic [WBUS_MAX-1:0] bus,
    input int                  idx,
    input int                  width
  );
    return MAX_WEIGHT_WIDTH'(bus >> (idx * width)) & MAX_WEIGHT_WIDTH'((1 << width) - 1);
  endfunction

endpackage

// File: rtl/nf10_rr_picker.sv
// Combinational rotating-priority encoder: first set bit of mask at or after start,
// wrapping around. Shared by the input and output schedulers.
module nf10_rr_picker
  import nf10_sched_pkg::*;
#(
  parameter int N  = 5,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] pick_idx
);

  int pos;

  always_comb begin
    found    = 1'b0;
    pick_idx = start;
    pos      = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(start) + k) % N;
      if (!found && mask[pos]) begin
        found    = 1'b1;
        pick_idx = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/nf10_wrr_scheduler.sv
// Weighted round-robin packet scheduler for the input arbiter: grants whole packets,
// up to weights[i] back-to-back packets per turn for queue i.
//
// state | meaning
// IDLE  | no owner; continue the current turn or search for the next queue
// GRANT | granted queue owns the datapath until its tlast handshake
module nf10_wrr_scheduler
  import nf10_sched_pkg::*;
#(
  parameter  int NUM_QUEUES   = 5,
  parameter  int WEIGHT_WIDTH = 4,
  localparam int QSEL_WIDTH   = clog2(NUM_QUEUES)
) (
  input  logic                               axi_aclk,
  input  logic                               axi_resetn,
  input  logic [NUM_QUEUES-1:0]              req,
  input  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0] weights,
  input  logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  input  logic                               m_axis_tlast,
  output logic                               grant_valid,
  output logic [QSEL_WIDTH-1:0]              grant_sel,
  output logic [NUM_QUEUES-1:0]              grant_onehot,
  output logic                               pkt_done
);

  sched_state_t            state_q, state_d;
  logic [QSEL_WIDTH-1:0]   ptr_q, ptr_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
  logic [WEIGHT_WIDTH-1:0] w_arr [NUM_QUEUES];
  logic [WBUS_MAX-1:0]     weights_ext;
  logic [NUM_QUEUES-1:0]   eligible;
  logic [QSEL_WIDTH-1:0]   start;
  logic [QSEL_WIDTH-1:0]   pick_idx;
  logic                    found;
  logic                    cont_turn;
  logic                    last_beat;
  logic                    grant_valid_d;
  logic [QSEL_WIDTH-1:0]   grant_sel_d;
  logic [NUM_QUEUES-1:0]   onehot_d;
  logic                    pkt_done_d;

  assign weights_ext = WBUS_MAX'(weights);

  always_comb begin
    for (int i = 0; i < NUM_QUEUES; i++) begin
      w_arr[i]    = WEIGHT_WIDTH'(weight_at(weights_ext, i, WEIGHT_WIDTH));
      eligible[i] = req[i] & (w_arr[i] != '0);
    end
  end

  // The current queue is searched last so a lone requester still gets a fresh turn.
  assign start     = (ptr_q == QSEL_WIDTH'(NUM_QUEUES - 1)) ? '0 : ptr_q + 1'b1;
  assign cont_turn = (credit_q != '0) && eligible[ptr_q];
  assign last_beat = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  nf10_rr_picker #(
    .N  (NUM_QUEUES),
    .IW (QSEL_WIDTH)
  ) u_picker (
    .mask     (eligible),
    .start    (start),
    .found    (found),
    .pick_idx (pick_idx)
  );

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    credit_d      = credit_q;
    grant_valid_d = 1'b0;
    grant_sel_d   = grant_sel;
    pkt_done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cont_turn) begin
          state_d       = GRANT;
          grant_valid_d = 1'b1;
          grant_sel_d   = ptr_q;
        end else if (found) begin
          state_d       = GRANT;
          ptr_d         = pick_idx;
          credit_d      = w_arr[pick_idx];
          grant_valid_d = 1'b1;
          grant_sel_d   = pick_idx;
        end
      end
      GRANT: begin
        grant_valid_d = 1'b1;
        if (last_beat) begin
          state_d       = IDLE;
          grant_valid_d = 1'b0;
          pkt_done_d    = 1'b1;
          if (credit_q != '0) credit_d = credit_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    onehot_d = grant_valid_d ? (NUM_QUEUES'(1) << grant_sel_d) : '0;
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q      <= IDLE;
      ptr_q        <= QSEL_WIDTH'(NUM_QUEUES - 1);
      credit_q     <= '0;
      grant_valid  <= 1'b0;
      grant_sel    <= '0;
      grant_onehot <= '0;
      pkt_done     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      credit_q     <= credit_d;
      grant_valid  <= grant_valid_d;
      grant_sel    <= grant_sel_d;
      grant_onehot <= onehot_d;
      pkt_done     <= pkt_done_d;
    end
  end

endmodule

// File: tb/tb_nf10_wrr_scheduler.sv
// Self-checking bench for nf10_wrr_scheduler: directed phases plus randomized
// traffic, compared against a packet-level weighted round-robin model.
module tb_nf10_wrr_scheduler;

  localparam int NQ = 5;
  localparam int WW = 4;
  localparam int QW = 3;

  logic              axi_aclk = 1'b0;
  logic              axi_resetn;
  logic [NQ-1:0]     req;
  logic [NQ*WW-1:0]  weights;
  logic              m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic              grant_valid;
  logic [QW-1:0]     grant_sel;
  logic [NQ-1:0]     grant_onehot;
  logic              pkt_done;

  nf10_wrr_scheduler #(.NUM_QUEUES(NQ), .WEIGHT_WIDTH(WW)) dut (
    .axi_aclk      (axi_aclk),
    .axi_resetn    (axi_resetn),
    .req           (req),
    .weights       (weights),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .grant_valid   (grant_valid),
    .grant_sel     (grant_sel),
    .grant_onehot  (grant_onehot),
    .pkt_done      (pkt_done)
  );

  always #5 axi_aclk = ~axi_aclk;

  int wq[NQ];
  int n_checks = 0;
  int n_pass   = 0;
  int m_cur;     // queue whose turn is in progress
  int m_credit;  // packets left in that turn

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic apply_weights();
    for (int i = 0; i < NQ; i++) weights[i*WW +: WW] = WW'(wq[i]);
  endtask

  task automatic set_all_weights(input int w);
    for (int i = 0; i < NQ; i++) wq[i] = w;
    apply_weights();
  endtask

  task automatic model_reset();
    m_cur    = NQ - 1;
    m_credit = 0;
  endtask

  // Which queue should own the next packet, or -1 if nobody is eligible.
  function automatic int model_pick();
    bit elig[NQ];
    for (int i = 0; i < NQ; i++) elig[i] = req[i] && (wq[i] != 0);
    if (m_credit > 0 && elig[m_cur]) return m_cur;
    for (int k = 1; k <= NQ; k++) begin
      int j;
      j = (m_cur + k) % NQ;
      if (elig[j]) begin
        m_cur    = j;
        m_credit = wq[j];
        return j;
      end
    end
    return -1;
  endfunction

  task automatic model_packet_done();
    if (m_credit > 0) m_credit--;
  endtask

  // Called at a negedge with the DUT in IDLE and req/weights just driven.
  task automatic run_packet(input int len, input int chg_q, input int chg_w);
    int exp;
    int tries;
    bit acc;
    exp = model_pick();
    if (exp < 0) begin
      m_axis_tvalid = 1'b1; m_axis_tready = 1'b1; m_axis_tlast = 1'b1;
      @(negedge axi_aclk);
      chk("idle_gv", int'(grant_valid), 0);
      chk("idle_done", int'(pkt_done), 0);
      chk("idle_onehot", int'(grant_onehot), 0);
      m_axis_tvalid = 1'b0; m_axis_tready = 1'b0; m_axis_tlast = 1'b0;
      return;
    end
    @(negedge axi_aclk);
    chk("grant_gv", int'(grant_valid), 1);
    chk("grant_sel", int'(grant_sel), exp);
    chk("grant_onehot", int'(grant_onehot), 1 << exp);
    if (chg_q >= 0) begin
      wq[chg_q] = chg_w;
      apply_weights();
    end
    for (int b = 0; b < len; b++) begin
      tries = 0;
      acc   = 1'b0;
      while (!acc) begin
        m_axis_tvalid = (tries >= 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
        m_axis_tready = (tries >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
        acc           = m_axis_tvalid && m_axis_tready;
        m_axis_tlast  = (b == len - 1) || (!acc && ($urandom_range(0, 2) == 0));
        @(negedge axi_aclk);
        tries++;
        if (acc && b == len - 1) begin
          chk("done_pulse", int'(pkt_done), 1);
          chk("done_gv", int'(grant_valid), 0);
          chk("done_onehot", int'(grant_onehot), 0);
        end else begin
          chk("hold_gv", int'(grant_valid), 1);
          chk("hold_sel", int'(grant_sel), exp);
          chk("hold_done", int'(pkt_done), 0);
        end
      end
    end
    m_axis_tvalid = 1'b0; m_axis_tready = 1'b0; m_axis_tlast = 1'b0;
    model_packet_done();
  endtask

  task automatic finish_single();
    m_axis_tvalid = 1'b1; m_axis_tready = 1'b1; m_axis_tlast = 1'b1;
    @(negedge axi_aclk);
    chk("single_done", int'(pkt_done), 1);
    chk("single_gv", int'(grant_valid), 0);
    m_axis_tvalid = 1'b0; m_axis_tready = 1'b0; m_axis_tlast = 1'b0;
    model_packet_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    axi_resetn = 1'b0;
    req = '0;
    m_axis_tvalid = 1'b0; m_axis_tready = 1'b0; m_axis_tlast = 1'b0;
    set_all_weights(1);
    model_reset();
    repeat (3) @(negedge axi_aclk);
    chk("rst_gv", int'(grant_valid), 0);
    chk("rst_sel", int'(grant_sel), 0);
    chk("rst_onehot", int'(grant_onehot), 0);
    chk("rst_done", int'(pkt_done), 0);
    axi_resetn = 1'b1;

    // Equal weights, single-beat packets back to back: 0,1,2,3,4,0.
    req = '1;
    for (int p = 0; p < 6; p++) run_packet(1, -1, 0);

    // Queue 0 weighted 3, four-beat packets.
    wq[0] = 3; apply_weights();
    for (int p = 0; p < 10; p++) run_packet(4, -1, 0);

    // Lone requester with weight 2 keeps getting fresh turns.
    set_all_weights(1); wq[2] = 2; apply_weights();
    req = 5'b00100;
    for (int p = 0; p < 5; p++) run_packet($urandom_range(1, 4), -1, 0);

    // Disabled queue 1, then enabled mid-packet.
    set_all_weights(1); wq[1] = 0; apply_weights();
    req = 5'b00011;
    for (int p = 0; p < 3; p++) run_packet(2, -1, 0);
    run_packet(3, 1, 1);
    for (int p = 0; p < 3; p++) run_packet(2, -1, 0);

    // Randomized traffic.
    for (int p = 0; p < 40; p++) begin
      req = NQ'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < NQ; i++) wq[i] = $urandom_range(0, 3);
        apply_weights();
      end
      if ($urandom_range(0, 4) == 0)
        run_packet($urandom_range(1, 4), $urandom_range(0, NQ - 1), $urandom_range(0, 3));
      else
        run_packet($urandom_range(1, 4), -1, 0);
    end

    // Asynchronous reset in the middle of a granted packet.
    set_all_weights(1);
    req = '1;
    e = model_pick();
    @(negedge axi_aclk);
    chk("pre_rst_gv", int'(grant_valid), 1);
    chk("pre_rst_sel", int'(grant_sel), e);
    m_axis_tvalid = 1'b1; m_axis_tready = 1'b0; m_axis_tlast = 1'b0;
    #2 axi_resetn = 1'b0;
    #1;
    chk("async_rst_gv", int'(grant_valid), 0);
    chk("async_rst_onehot", int'(grant_onehot), 0);
    chk("async_rst_done", int'(pkt_done), 0);
    m_axis_tvalid = 1'b0;
    @(negedge axi_aclk);
    axi_resetn = 1'b1;
    model_reset();
    req = 5'b10001;
    e = model_pick();
    @(negedge axi_aclk);
    chk("post_rst_gv", int'(grant_valid), 1);
    chk("post_rst_first_q0", int'(grant_sel), 0);
    finish_single();

    // Long idle period, then a lone request on queue 3.
    req = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge axi_aclk);
      chk("quiet_gv", int'(grant_valid), 0);
    end
    req = 5'b01000;
    e = model_pick();
    chk("req3_same_cycle_gv", int'(grant_valid), 0);
    @(negedge axi_aclk);
    chk("req3_gv", int'(grant_valid), 1);
    chk("req3_sel", int'(grant_sel), 3);
    chk("req3_onehot", int'(grant_onehot), 8);
    finish_single();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
